// File: rtl/spi_regfifo_pkg.sv
// Shared types and address-map helpers for the SPI register/FIFO slave.
// The address constants depend on module parameters, so they are exposed as functions.
package spi_regfifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA_WR,
      ST_DATA_RD
   } spi_state_t;

   localparam int SUM_ADDR = 0;

   function automatic int read_bit_idx(input int cmd_w);
      return cmd_w - 1;
   endfunction

   function automatic int fifo_addr(input int num_regs);
      return num_regs + 1;
   endfunction

   function automatic int stat_addr(input int num_regs);
      return num_regs + 2;
   endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers one bit wider than the address.
// Pushes while full and pops while empty are ignored; the caller tracks the error flags.
module spi_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr_reg;
   logic [AW:0]       rd_ptr_reg;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count    = wr_ptr_reg - rd_ptr_reg;
   // Head word is presented combinationally so a pop can load it in the same cycle.
   assign pop_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_regfifo_slave.sv
// SPI slave with separate command/data selects: register bank, SUM readback, FIFO channel
// and sticky STATUS word. All SPI pins are resynchronised and edge-detected in the clk domain.
module spi_regfifo_slave
   import spi_regfifo_pkg::*;
#(
   parameter int CMD_W      = 8,
   parameter int DATA_W     = 16,
   parameter int NUM_REGS   = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int SPI_MODE   = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_scl,
   input  logic spi_sdi,
   input  logic spi_cs_cmd,
   input  logic spi_cs_data,
   output logic spi_sdo
);

   localparam int AW     = CMD_W - 1;
   localparam int RX_W   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int CNT_W  = $clog2(RX_W + 2);
   localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
   localparam int RD_BIT = read_bit_idx(CMD_W);
   localparam logic          SCL_IDLE = (SPI_MODE == 3);
   localparam logic [AW-1:0] SUM_A    = AW'(SUM_ADDR);
   localparam logic [AW-1:0] FIFO_A   = AW'(fifo_addr(NUM_REGS));
   localparam logic [AW-1:0] STAT_A   = AW'(stat_addr(NUM_REGS));

   logic [2:0] scl_sr_reg, cs_cmd_sr_reg, cs_data_sr_reg;
   logic [1:0] sdi_sr_reg;

   // Two sync stages plus one history stage for edge detection; scl idles per SPI mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sr_reg     <= {3{SCL_IDLE}};
         sdi_sr_reg     <= '0;
         cs_cmd_sr_reg  <= '1;
         cs_data_sr_reg <= '1;
      end else begin
         scl_sr_reg     <= {scl_sr_reg[1:0], spi_scl};
         sdi_sr_reg     <= {sdi_sr_reg[0], spi_sdi};
         cs_cmd_sr_reg  <= {cs_cmd_sr_reg[1:0], spi_cs_cmd};
         cs_data_sr_reg <= {cs_data_sr_reg[1:0], spi_cs_data};
      end
   end

   logic scl_rise, sdi_s, cs_cmd_s, cs_cmd_fall, cs_cmd_rise, cs_data_fall, cs_data_rise;
   assign scl_rise     = scl_sr_reg[1] & ~scl_sr_reg[2];
   assign sdi_s        = sdi_sr_reg[1];
   assign cs_cmd_s     = cs_cmd_sr_reg[1];
   assign cs_cmd_fall  = ~cs_cmd_sr_reg[1] & cs_cmd_sr_reg[2];
   assign cs_cmd_rise  = cs_cmd_sr_reg[1] & ~cs_cmd_sr_reg[2];
   assign cs_data_fall = ~cs_data_sr_reg[1] & cs_data_sr_reg[2];
   assign cs_data_rise = cs_data_sr_reg[1] & ~cs_data_sr_reg[2];

   spi_state_t        state_reg, state_next;
   logic [CMD_W-1:0]  cmd_reg;
   logic [RX_W-1:0]   rx_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic [DATA_W-1:0] tx_reg;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              ovf_reg, unf_reg;
   logic              latch_cmd, commit_wr, load_rd, clr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // A command select falling always wins; a data frame is only entered while cs_cmd is high.
   always_comb begin
      state_next = state_reg;
      latch_cmd  = 1'b0;
      commit_wr  = 1'b0;
      load_rd    = 1'b0;
      clr_cnt    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cs_cmd_fall) begin
               state_next = ST_CMD;
               clr_cnt    = 1'b1;
            end else if (cs_data_fall && cs_cmd_s) begin
               clr_cnt = 1'b1;
               if (cmd_reg[RD_BIT]) begin
                  state_next = ST_DATA_RD;
                  load_rd    = 1'b1;
               end else begin
                  state_next = ST_DATA_WR;
               end
            end
         end
         ST_CMD: begin
            if (cs_cmd_rise) begin
               state_next = ST_IDLE;
               latch_cmd  = (bit_cnt_reg == CNT_W'(CMD_W));
            end
         end
         ST_DATA_WR, ST_DATA_RD: begin
            if (cs_cmd_fall) begin
               state_next = ST_CMD;
               clr_cnt    = 1'b1;
            end else if (cs_data_rise) begin
               state_next = ST_IDLE;
               commit_wr  = (state_reg == ST_DATA_WR) && (bit_cnt_reg == CNT_W'(DATA_W));
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] sum, status_word, rd_word, fifo_dout;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [FCW-1:0]    fifo_count;

   assign addr = cmd_reg[AW-1:0];

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_REGS; i++) sum = sum + regs[i];
      status_word             = '0;
      status_word[FCW-1:0]    = fifo_count;
      status_word[DATA_W-1]   = ovf_reg;
      status_word[DATA_W-2]   = unf_reg;
      rd_word = '0;
      if (addr == SUM_A)       rd_word = sum;
      else if (addr == FIFO_A) rd_word = fifo_empty ? '0 : fifo_dout;
      else if (addr == STAT_A) rd_word = status_word;
      else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == AW'(i + 1)) rd_word = regs[i];
         end
      end
   end

   assign fifo_push = commit_wr && (addr == FIFO_A) && !fifo_full;
   assign fifo_pop  = load_rd && (addr == FIFO_A) && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_reg     <= '0;
         rx_reg      <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= '0;
         ovf_reg     <= 1'b0;
         unf_reg     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (clr_cnt) begin
            bit_cnt_reg <= '0;
         end else if (scl_rise && (state_reg == ST_CMD || state_reg == ST_DATA_WR)
                      && bit_cnt_reg != '1) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
         end
         if (scl_rise && (state_reg == ST_CMD || state_reg == ST_DATA_WR)) begin
            rx_reg <= {rx_reg[RX_W-2:0], sdi_s};
         end
         if (latch_cmd) cmd_reg <= rx_reg[CMD_W-1:0];
         // Refilling with the LSB keeps the last driven bit on sdo after the word runs out.
         if (load_rd) begin
            tx_reg <= rd_word;
         end else if (scl_rise && state_reg == ST_DATA_RD) begin
            tx_reg <= {tx_reg[DATA_W-2:0], tx_reg[0]};
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_wr && addr == AW'(i + 1)) regs[i] <= rx_reg[DATA_W-1:0];
         end
         if (commit_wr && addr == STAT_A) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
         end
         if (commit_wr && addr == FIFO_A && fifo_full)  ovf_reg <= 1'b1;
         if (load_rd && addr == FIFO_A && fifo_empty)   unf_reg <= 1'b1;
      end
   end

   assign spi_sdo = tx_reg[DATA_W-1];

   spi_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (rx_reg[DATA_W-1:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_spi_regfifo_slave.sv
// Drives a mode-0 and a mode-3 instance with identical SPI traffic and checks both
// against a word-level model of the register map, FIFO queue and sticky flags.
module tb_spi_regfifo_slave;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl0 = 1'b0;
   logic scl3 = 1'b1;
   logic sdi = 1'b0;
   logic cs_cmd = 1'b1;
   logic cs_data = 1'b1;
   logic sdo0, sdo3;

   always #5 clk = ~clk;

   spi_regfifo_slave #(.SPI_MODE(0)) dut_m0 (
      .clk(clk), .rst_n(rst_n), .spi_scl(scl0), .spi_sdi(sdi),
      .spi_cs_cmd(cs_cmd), .spi_cs_data(cs_data), .spi_sdo(sdo0)
   );

   spi_regfifo_slave #(.SPI_MODE(3)) dut_m3 (
      .clk(clk), .rst_n(rst_n), .spi_scl(scl3), .spi_sdi(sdi),
      .spi_cs_cmd(cs_cmd), .spi_cs_data(cs_data), .spi_sdo(sdo3)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [15:0] m_regs [1:3];
   logic [15:0] fifo_q [$];
   logic        m_ovf, m_unf;
   logic [7:0]  m_cmd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 1; i <= 3; i++) m_regs[i] = '0;
      fifo_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_cmd = '0;
   endtask

   task automatic model_read(output logic [15:0] e);
      int a;
      a = int'(m_cmd[6:0]);
      e = '0;
      if (a == 0) begin
         e = m_regs[1] + m_regs[2] + m_regs[3];
      end else if (a >= 1 && a <= 3) begin
         e = m_regs[a];
      end else if (a == 4) begin
         if (fifo_q.size() == 0) m_unf = 1'b1;
         else e = fifo_q.pop_front();
      end else if (a == 5) begin
         e = {m_ovf, m_unf, 9'd0, 5'(fifo_q.size())};
      end
   endtask

   task automatic model_write(input logic [15:0] v);
      int a;
      a = int'(m_cmd[6:0]);
      if (a >= 1 && a <= 3) m_regs[a] = v;
      else if (a == 4) begin
         if (fifo_q.size() == 16) m_ovf = 1'b1;
         else fifo_q.push_back(v);
      end else if (a == 5) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
   endtask

   // One SPI bit: sdo sampled just before the shared sampling rise of both clocks.
   task automatic sbit(input logic b, output logic s0, output logic s3);
      sdi = b;
      scl3 = 1'b0;
      #40;
      s0 = sdo0;
      s3 = sdo3;
      scl0 = 1'b1;
      scl3 = 1'b1;
      #40;
      scl0 = 1'b0;
   endtask

   task automatic frame(input bit is_cmd, input logic [15:0] tx, input int nbits,
                        output logic [15:0] rx0, output logic [15:0] rx3);
      logic a, b;
      rx0 = '0;
      rx3 = '0;
      if (is_cmd) cs_cmd = 1'b0;
      else cs_data = 1'b0;
      #40;
      for (int i = nbits - 1; i >= 0; i--) begin
         sbit(tx[i], a, b);
         rx0 = {rx0[14:0], a};
         rx3 = {rx3[14:0], b};
      end
      #40;
      cs_cmd = 1'b1;
      cs_data = 1'b1;
      #80;
   endtask

   task automatic do_cmd(input logic [7:0] c, input int nbits);
      logic [15:0] r0, r3;
      frame(1'b1, {8'd0, c}, nbits, r0, r3);
      if (nbits == 8) m_cmd = c;
   endtask

   task automatic do_data(input logic [15:0] v, input int nbits, input string tag);
      logic [15:0] r0, r3, e;
      if (m_cmd[7]) begin
         model_read(e);
         frame(1'b0, v, 16, r0, r3);
         check({tag, " mode0"}, {16'd0, r0}, {16'd0, e});
         check({tag, " mode3"}, {16'd0, r3}, {16'd0, e});
      end else begin
         frame(1'b0, v, nbits, r0, r3);
         if (nbits == 16) model_write(v);
      end
   endtask

   initial begin
      logic [7:0] c;
      logic a, b;
      model_reset();
      #100;
      check("reset sdo mode0", {31'd0, sdo0}, 32'd0);
      check("reset sdo mode3", {31'd0, sdo3}, 32'd0);
      rst_n = 1'b1;
      #100;

      // Register sum with 16-bit wrap, then direct readback.
      do_cmd(8'h01, 8); do_data(16'h1234, 16, "wr r1");
      do_cmd(8'h02, 8); do_data(16'h0F0F, 16, "wr r2");
      do_cmd(8'h03, 8); do_data(16'hFFFF, 16, "wr r3");
      do_cmd(8'h80, 8); do_data(16'h0000, 16, "sum");
      do_cmd(8'h82, 8); do_data(16'h0000, 16, "rd r2");

      // FIFO ordering.
      do_cmd(8'h04, 8);
      for (int i = 1; i <= 10; i++) do_data(16'(i), 16, "push");
      do_cmd(8'h84, 8);
      for (int i = 1; i <= 10; i++) do_data(16'h0, 16, "pop order");
      do_cmd(8'h85, 8); do_data(16'h0, 16, "status empty");

      // Overflow, drain, underflow, flag clear.
      do_cmd(8'h04, 8);
      for (int i = 0; i < 17; i++) do_data(16'h0100 + 16'(i), 16, "push ovf");
      do_cmd(8'h85, 8); do_data(16'h0, 16, "status ovf");
      do_cmd(8'h84, 8);
      for (int i = 0; i < 17; i++) do_data(16'h0, 16, "pop drain");
      do_cmd(8'h85, 8); do_data(16'h0, 16, "status unf");
      do_cmd(8'h05, 8); do_data(16'hA5A5, 16, "wr status");
      do_cmd(8'h85, 8); do_data(16'h0, 16, "status clr");

      // Partial frames: a short command keeps 0x85; a short write leaves reg 1.
      do_cmd(8'h01, 5); do_data(16'h0, 16, "partial cmd");
      do_cmd(8'h01, 8); do_data(16'hBEEF, 9, "partial wr");
      do_cmd(8'h81, 8); do_data(16'h0, 16, "rd r1 after partial");

      // Randomised traffic over the full address range.
      for (int t = 0; t < 40; t++) begin
         c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
         if ($urandom_range(0, 9) == 0) c[6:0] = 7'h7F;
         do_cmd(c, ($urandom_range(0, 9) == 0) ? 7 : 8);
         for (int k = $urandom_range(1, 4); k > 0; k--) begin
            do_data(16'($urandom), ($urandom_range(0, 7) == 0) ? 15 : 16, "random");
         end
      end

      // Reset in the middle of a read frame.
      do_cmd(8'h01, 8); do_data(16'hFFFF, 16, "wr r1 pre-reset");
      do_cmd(8'h81, 8);
      cs_data = 1'b0;
      #40;
      for (int i = 0; i < 7; i++) sbit(1'b0, a, b);
      rst_n = 1'b0;
      #20;
      check("midframe rst sdo mode0", {31'd0, sdo0}, 32'd0);
      check("midframe rst sdo mode3", {31'd0, sdo3}, 32'd0);
      cs_data = 1'b1;
      #40;
      rst_n = 1'b1;
      model_reset();
      #80;
      for (int i = 0; i <= 3; i++) begin
         do_cmd(8'h80 | 8'(i), 8); do_data(16'h0, 16, "post-rst rd");
      end
      do_cmd(8'h85, 8); do_data(16'h0, 16, "post-rst status");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
